vga_timing_gen: RTL and testbench

VGA raster timing generator for the display path. Runs on the 100 MHz system clock and advances one pixel per `pix_en_i` strobe, normally the 1-in-4 (25 MHz) pixel-rate enable, so no derived clock enters this domain. Produces horizontal/vertical sync, the data-enable window and the current pixel coordinates that feed the pixel source and the VGA pins. Default parameters give 640x480 @ 60 Hz.

---
 rtl/vga_timing_if.sv | 32 +++
 rtl/vga_timing_gen.sv | 151 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_if.sv
// vga_timing_if
// Raster timing bundle between the VGA timing generator and its consumers
// (pixel source, VGA pin drivers).
//   pix_en_i      : pixel strobe into the generator (one raster step per strobe)
//   hsync_o       : horizontal sync
//   vsync_o       : vertical sync
//   de_o          : data enable, high inside the visible region
//   x_o, y_o      : current pixel coordinates
//   line_start_o  : high for the pixel period with x=0
//   frame_start_o : high for the pixel period with x=0, y=0
interface vga_timing_if;
  logic       pix_en_i;
  logic       hsync_o;
  logic       vsync_o;
  logic       de_o;
  logic [9:0] x_o;
  logic [9:0] y_o;
  logic       line_start_o;
  logic       frame_start_o;

  // Generator side
  modport master (
    input  pix_en_i,
    output hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );

  // Consumer side (also owns the pixel strobe)
  modport slave (
    output pix_en_i,
    input  hsync_o, vsync_o, de_o, x_o, y_o, line_start_o, frame_start_o
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing generator. Runs on the system clock and advances one
// pixel per pix_en_i strobe. Defaults give 640x480 @ 60 Hz.
// Ports:
//   clk_i  : system clock, single clock domain
//   rst_ni : asynchronous active-low reset
//   vga    : vga_timing_if.master (pix_en_i in; sync, de, coordinates,
//            line/frame start pulses out, all registered)
// Both totals must not exceed 1024 and every porch/sync/active width must be
// at least 1, since each phase is left on its own last count.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  vga_timing_if.master vga
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last count of each phase; the phase FSM moves on when leaving it.
  localparam logic [9:0] H_ACT_LAST  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] H_FP_LAST   = 10'(H_ACTIVE + H_FP - 1);
  localparam logic [9:0] H_SYNC_LAST = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_ACTIVE - 1);
  localparam logic [9:0] V_FP_LAST   = 10'(V_ACTIVE + V_FP - 1);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);

  localparam logic SYNC_ON  = 1'(SYNC_POL);
  localparam logic SYNC_OFF = ~SYNC_ON;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FP     = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BP     = 2'd3
  } phase_e;

  // Counters and phases describe the position presented on the next strobe.
  logic [9:0] h_r, v_r;
  phase_e     h_ph_r, v_ph_r;
  logic       hsync_r, vsync_r, de_r, ls_r, fs_r;
  logic [9:0] x_r, y_r;

  logic [9:0] h_nxt_s, v_nxt_s;
  phase_e     h_ph_nxt_s, v_ph_nxt_s;
  logic       hsync_nxt_s, vsync_nxt_s, de_nxt_s, ls_nxt_s, fs_nxt_s;
  logic [9:0] x_nxt_s, y_nxt_s;
  logic       h_wrap_s;

  // State and output registers; reset drives syncs to their inactive level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_r     <= 10'd0;
      v_r     <= 10'd0;
      h_ph_r  <= PH_ACTIVE;
      v_ph_r  <= PH_ACTIVE;
      hsync_r <= SYNC_OFF;
      vsync_r <= SYNC_OFF;
      de_r    <= 1'b0;
      x_r     <= 10'd0;
      y_r     <= 10'd0;
      ls_r    <= 1'b0;
      fs_r    <= 1'b0;
    end else begin
      h_r     <= h_nxt_s;
      v_r     <= v_nxt_s;
      h_ph_r  <= h_ph_nxt_s;
      v_ph_r  <= v_ph_nxt_s;
      hsync_r <= hsync_nxt_s;
      vsync_r <= vsync_nxt_s;
      de_r    <= de_nxt_s;
      x_r     <= x_nxt_s;
      y_r     <= y_nxt_s;
      ls_r    <= ls_nxt_s;
      fs_r    <= fs_nxt_s;
    end
  end

  // Next-state of both phase FSMs and counters, plus next registered outputs.
  always_comb begin
    h_wrap_s    = (h_r == H_LAST);
    h_nxt_s     = h_r;
    v_nxt_s     = v_r;
    h_ph_nxt_s  = h_ph_r;
    v_ph_nxt_s  = v_ph_r;
    hsync_nxt_s = hsync_r;
    vsync_nxt_s = vsync_r;
    de_nxt_s    = de_r;
    x_nxt_s     = x_r;
    y_nxt_s     = y_r;
    ls_nxt_s    = ls_r;
    fs_nxt_s    = fs_r;

    if (vga.pix_en_i) begin
      // Present the current position, derived from the phase states.
      x_nxt_s     = h_r;
      y_nxt_s     = v_r;
      de_nxt_s    = (h_ph_r == PH_ACTIVE) && (v_ph_r == PH_ACTIVE);
      hsync_nxt_s = (h_ph_r == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      vsync_nxt_s = (v_ph_r == PH_SYNC) ? SYNC_ON : SYNC_OFF;
      ls_nxt_s    = (h_r == 10'd0);
      fs_nxt_s    = (h_r == 10'd0) && (v_r == 10'd0);

      // Advance the raster.
      h_nxt_s = h_wrap_s ? 10'd0 : (h_r + 10'd1);
      v_nxt_s = h_wrap_s ? ((v_r == V_LAST) ? 10'd0 : (v_r + 10'd1)) : v_r;

      case (h_ph_r)
        PH_ACTIVE: h_ph_nxt_s = (h_r == H_ACT_LAST)  ? PH_FP     : PH_ACTIVE;
        PH_FP:     h_ph_nxt_s = (h_r == H_FP_LAST)   ? PH_SYNC   : PH_FP;
        PH_SYNC:   h_ph_nxt_s = (h_r == H_SYNC_LAST) ? PH_BP     : PH_SYNC;
        PH_BP:     h_ph_nxt_s = (h_r == H_LAST)      ? PH_ACTIVE : PH_BP;
        default:   h_ph_nxt_s = PH_ACTIVE;
      endcase

      // Vertical phase only moves on the horizontal wrap, so vsync edges
      // line up with x=0 of a line.
      case (v_ph_r)
        PH_ACTIVE: v_ph_nxt_s = (h_wrap_s && (v_r == V_ACT_LAST))  ? PH_FP     : PH_ACTIVE;
        PH_FP:     v_ph_nxt_s = (h_wrap_s && (v_r == V_FP_LAST))   ? PH_SYNC   : PH_FP;
        PH_SYNC:   v_ph_nxt_s = (h_wrap_s && (v_r == V_SYNC_LAST)) ? PH_BP     : PH_SYNC;
        PH_BP:     v_ph_nxt_s = (h_wrap_s && (v_r == V_LAST))      ? PH_ACTIVE : PH_BP;
        default:   v_ph_nxt_s = PH_ACTIVE;
      endcase
    end else begin
      h_nxt_s = h_r;
      v_nxt_s = v_r;
    end
  end

  assign vga.hsync_o       = hsync_r;
  assign vga.vsync_o       = vsync_r;
  assign vga.de_o          = de_r;
  assign vga.x_o           = x_r;
  assign vga.y_o           = y_r;
  assign vga.line_start_o  = ls_r;
  assign vga.frame_start_o = fs_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed testbench for vga_timing_gen. Three instances: default timing,
// default timing with SYNC_POL=1 and pix_en tied high, and a miniature
// raster (15x13 totals) so whole frames fit in a short run.
module tb_vga_timing_gen;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk_i = ~clk_i;

  vga_timing_if if_def ();
  vga_timing_if if_pol ();
  vga_timing_if if_sml ();

  assign if_pol.pix_en_i = 1'b1;

  vga_timing_gen u_def (.clk_i(clk_i), .rst_ni(rst_ni), .vga(if_def));

  vga_timing_gen #(.SYNC_POL(1)) u_pol (.clk_i(clk_i), .rst_ni(rst_ni), .vga(if_pol));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(0)
  ) u_sml (.clk_i(clk_i), .rst_ni(rst_ni), .vga(if_sml));

  // {de, x, y, line_start, frame_start, hsync, vsync}
  logic [24:0] got_v, exp_v;

  // One strobe every 4th clock; outputs are valid when this returns.
  task automatic strobe(input bit d, input bit s);
    repeat (2) @(negedge clk_i);
    @(negedge clk_i);
    if_def.pix_en_i = d;
    if_sml.pix_en_i = s;
    @(negedge clk_i);
    if_def.pix_en_i = 1'b0;
    if_sml.pix_en_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    rst_ni = 1'b0;
    #1;
    got_v = {if_def.de_o, if_def.x_o, if_def.y_o, if_def.line_start_o,
             if_def.frame_start_o, if_def.hsync_o, if_def.vsync_o};
    exp_v = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_def: got %h expected %h", got_v, exp_v);
    end
    got_v = {if_pol.de_o, if_pol.x_o, if_pol.y_o, if_pol.line_start_o,
             if_pol.frame_start_o, if_pol.hsync_o, if_pol.vsync_o};
    exp_v = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL reset_pol: got %h expected %h", got_v, exp_v);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    strobe(1'b1, 1'b1);
    got_v = {if_def.de_o, if_def.x_o, if_def.y_o, if_def.line_start_o,
             if_def.frame_start_o, if_def.hsync_o, if_def.vsync_o};
    exp_v = {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL first_strobe_def: got %h expected %h", got_v, exp_v);
    end
    got_v = {if_sml.de_o, if_sml.x_o, if_sml.y_o, if_sml.line_start_o,
             if_sml.frame_start_o, if_sml.hsync_o, if_sml.vsync_o};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL first_strobe_sml: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_line();
    int bad = 0;
    int first_bad = -1;
    int de_cnt = 0;
    int hs_cnt = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      strobe(1'b1, 1'b0);
      exp_v = {(i < 640), 10'(i), 10'd0, (i == 0), (i == 0),
               !((i >= 656) && (i <= 751)), 1'b1};
      got_v = {if_def.de_o, if_def.x_o, if_def.y_o, if_def.line_start_o,
               if_def.frame_start_o, if_def.hsync_o, if_def.vsync_o};
      if (got_v !== exp_v) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if (if_def.de_o === 1'b1) de_cnt++;
      if (if_def.hsync_o === 1'b0) hs_cnt++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL line_pattern: %0d bad strobes (first x=%0d) expected 0", bad, first_bad);
    end
    n_checks++;
    if (de_cnt != 640) begin
      n_fail++;
      $display("FAIL line_de_count: got %0d expected 640", de_cnt);
    end
    n_checks++;
    if (hs_cnt != 96) begin
      n_fail++;
      $display("FAIL line_hsync_count: got %0d expected 96", hs_cnt);
    end
    strobe(1'b1, 1'b0);
    got_v = {if_def.de_o, if_def.x_o, if_def.y_o, if_def.line_start_o,
             if_def.frame_start_o, if_def.hsync_o, if_def.vsync_o};
    exp_v = {1'b1, 10'd0, 10'd1, 1'b1, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL line_wrap: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_hold();
    int bad = 0;
    repeat (300) strobe(1'b1, 1'b0);
    exp_v = {1'b1, 10'd300, 10'd1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      got_v = {if_def.de_o, if_def.x_o, if_def.y_o, if_def.line_start_o,
               if_def.frame_start_o, if_def.hsync_o, if_def.vsync_o};
      if (got_v !== exp_v) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold_stable: %0d changed clocks expected 0 (last %h vs %h)", bad, got_v, exp_v);
    end
    strobe(1'b1, 1'b0);
    n_checks++;
    if ({if_def.x_o, if_def.y_o} !== {10'd301, 10'd1}) begin
      n_fail++;
      $display("FAIL hold_resume: got x=%0d y=%0d expected x=301 y=1", if_def.x_o, if_def.y_o);
    end
  endtask

  task automatic test_frame();
    int bad = 0;
    int first_bad = -1;
    int vs_cnt = 0;
    int fs_cnt = 0;
    int xe = 0;
    int ye = 0;
    do_reset();
    for (int i = 0; i < 391; i++) begin
      strobe(1'b0, 1'b1);
      exp_v = {((xe < 8) && (ye < 6)), 10'(xe), 10'(ye), (xe == 0),
               ((xe == 0) && (ye == 0)), !((xe >= 10) && (xe <= 12)),
               !((ye >= 8) && (ye <= 9))};
      got_v = {if_sml.de_o, if_sml.x_o, if_sml.y_o, if_sml.line_start_o,
               if_sml.frame_start_o, if_sml.hsync_o, if_sml.vsync_o};
      if (got_v !== exp_v) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if ((i < 195) && (if_sml.vsync_o === 1'b0)) vs_cnt++;
      if (if_sml.frame_start_o === 1'b1) fs_cnt++;
      if (xe == 14) begin
        xe = 0;
        ye = (ye == 12) ? 0 : ye + 1;
      end else begin
        xe = xe + 1;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL frame_pattern: %0d bad strobes (first %0d) expected 0", bad, first_bad);
    end
    n_checks++;
    if (vs_cnt != 30) begin
      n_fail++;
      $display("FAIL frame_vsync_count: got %0d expected 30", vs_cnt);
    end
    n_checks++;
    if (fs_cnt != 3) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d expected 3", fs_cnt);
    end
  endtask

  task automatic test_midframe_reset();
    repeat (147) strobe(1'b0, 1'b1);
    n_checks++;
    if ({if_sml.x_o, if_sml.y_o, if_sml.hsync_o, if_sml.vsync_o} !== {10'd12, 10'd9, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_position: got x=%0d y=%0d hs=%b vs=%b expected x=12 y=9 hs=0 vs=0",
               if_sml.x_o, if_sml.y_o, if_sml.hsync_o, if_sml.vsync_o);
    end
    #2;
    rst_ni = 1'b0;
    #1;
    got_v = {if_sml.de_o, if_sml.x_o, if_sml.y_o, if_sml.line_start_o,
             if_sml.frame_start_o, if_sml.hsync_o, if_sml.vsync_o};
    exp_v = {1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_async: got %h expected %h", got_v, exp_v);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    strobe(1'b1, 1'b1);
    got_v = {if_sml.de_o, if_sml.x_o, if_sml.y_o, if_sml.line_start_o,
             if_sml.frame_start_o, if_sml.hsync_o, if_sml.vsync_o};
    exp_v = {1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1};
    n_checks++;
    if (got_v !== exp_v) begin
      n_fail++;
      $display("FAIL mid_reset_restart: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_sync_pol();
    int bad = 0;
    int first_bad = -1;
    int hs_cnt = 0;
    int ls_cnt = 0;
    int xe;
    do_reset();
    for (int k = 0; k < 1600; k++) begin
      @(negedge clk_i);
      xe = k % 800;
      exp_v = {(xe < 640), 10'(xe), 10'(k / 800), (xe == 0), (k == 0),
               ((xe >= 656) && (xe <= 751)), 1'b0};
      got_v = {if_pol.de_o, if_pol.x_o, if_pol.y_o, if_pol.line_start_o,
               if_pol.frame_start_o, if_pol.hsync_o, if_pol.vsync_o};
      if (got_v !== exp_v) begin
        if (bad == 0) first_bad = k;
        bad++;
      end
      if ((k < 800) && (if_pol.hsync_o === 1'b1)) hs_cnt++;
      if (if_pol.line_start_o === 1'b1) ls_cnt++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL pol_pattern: %0d bad cycles (first %0d) expected 0", bad, first_bad);
    end
    n_checks++;
    if (hs_cnt != 96) begin
      n_fail++;
      $display("FAIL pol_hsync_count: got %0d expected 96", hs_cnt);
    end
    n_checks++;
    if (ls_cnt != 2) begin
      n_fail++;
      $display("FAIL pol_line_starts: got %0d expected 2", ls_cnt);
    end
  endtask

  initial begin
    if_def.pix_en_i = 1'b0;
    if_sml.pix_en_i = 1'b0;
    test_reset();
    test_line();
    test_hold();
    test_frame();
    test_midframe_reset();
    test_sync_pol();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
